// File: rtl/ddr3_mon_pkg.sv
// DDR3 traffic monitor shared definitions.
// Command encodings, snapshot FSM states and the decoded event bundle.
package ddr3_mon_pkg;

    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_LOAD
    } snap_state_e;

    typedef struct packed {
        logic rd_acc;
        logic rd_stall;
        logic wr_acc;
        logic wr_stall;
    } mon_ev_t;

    function automatic mon_ev_t decode_ev(
        input logic       en,
        input logic       app_en,
        input logic       app_rdy,
        input logic [2:0] app_cmd,
        input logic       wdf_wren,
        input logic       wdf_rdy
    );
        mon_ev_t ev;
        logic    is_rd;
        logic    is_wr;
        is_rd       = app_en && (app_cmd == CMD_READ);
        is_wr       = app_en && (app_cmd == CMD_WRITE);
        ev.rd_acc   = en && is_rd && app_rdy;
        ev.rd_stall = en && is_rd && !app_rdy;
        ev.wr_acc   = en && is_wr && app_rdy;
        ev.wr_stall = en && ((is_wr && !app_rdy) ||
                             (wdf_wren && !wdf_rdy));
        return ev;
    endfunction

endpackage

// File: rtl/ddr3_stall_tracker.sv
// Consecutive stall run length and longest run seen, both saturating.
// peak_o folds any run still in progress into the maximum.
import ddr3_mon_pkg::*;

module ddr3_stall_tracker #(
    parameter int pW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic          stall_i,
    output logic [pW-1:0] peak_o
);

    localparam logic [pW-1:0] ONE = pW'(1);

    logic [pW-1:0] run_d;
    logic [pW-1:0] run_q;
    logic [pW-1:0] max_d;
    logic [pW-1:0] max_q;

    // extend the run on stall; close it into max otherwise
    always_comb begin
        run_d = run_q;
        max_d = max_q;
        if (clr_i) begin
            run_d = '0;
            max_d = '0;
        end else if (!en_i || !stall_i) begin
            if (run_q > max_q) begin
                max_d = run_q;
            end
            run_d = '0;
        end else begin
            if (run_q != '1) begin
                run_d = run_q + ONE;
            end
            if ((run_d == '1) && (run_d > max_q)) begin
                max_d = run_d;
            end
        end
    end

    // run and max registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
            max_q <= '0;
        end else begin
            run_q <= run_d;
            max_q <= max_d;
        end
    end

    assign peak_o = (run_q > max_q) ? run_q : max_q;

endmodule

// File: rtl/ddr3_traffic_monitor.sv
// Passive DDR3 UI-side traffic monitor with periodic stable snapshots.
// Live counters accumulate until clear; snapshots copy them in LOAD.
import ddr3_mon_pkg::*;

module ddr3_traffic_monitor #(
    parameter int pCOUNT_WIDTH = 32,
    parameter int pSTALL_WIDTH = 16,
    parameter int pSNAP_PERIOD = 1024
) (
    input  logic                    ui_clk,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic                    app_en,
    input  logic                    app_rdy,
    input  logic [2:0]              app_cmd,
    input  logic                    app_wdf_wren,
    input  logic                    app_wdf_rdy,
    output logic [pCOUNT_WIDTH-1:0] read_read_o,
    output logic [pCOUNT_WIDTH-1:0] read_idle_o,
    output logic [pCOUNT_WIDTH-1:0] write_write_o,
    output logic [pCOUNT_WIDTH-1:0] write_idle_o,
    output logic [pSTALL_WIDTH-1:0] max_read_stall_o,
    output logic [pSTALL_WIDTH-1:0] max_write_stall_o,
    output logic                    snap_toggle_o
);

    localparam int PW = (pSNAP_PERIOD > 1) ? $clog2(pSNAP_PERIOD) : 1;
    localparam logic [PW-1:0] TERM = PW'(pSNAP_PERIOD - 1);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [pCOUNT_WIDTH-1:0] C_ONE = pCOUNT_WIDTH'(1);

    typedef logic [pCOUNT_WIDTH-1:0] cnt_t;
    typedef logic [pSTALL_WIDTH-1:0] stl_t;

    function automatic cnt_t sat_inc(input cnt_t c, input logic hit);
        return (hit && (c != '1)) ? c + C_ONE : c;
    endfunction

    mon_ev_t ev_d;
    mon_ev_t ev_q;
    logic    en_d;
    logic    en_q;

    cnt_t rd_cnt_d;
    cnt_t rd_cnt_q;
    cnt_t rd_idle_d;
    cnt_t rd_idle_q;
    cnt_t wr_cnt_d;
    cnt_t wr_cnt_q;
    cnt_t wr_idle_d;
    cnt_t wr_idle_q;

    stl_t rd_peak;
    stl_t wr_peak;

    snap_state_e state_d;
    snap_state_e state_q;
    logic [PW-1:0] per_d;
    logic [PW-1:0] per_q;
    logic pend_d;
    logic pend_q;
    logic load;

    cnt_t s_rd_d;
    cnt_t s_rd_q;
    cnt_t s_ri_d;
    cnt_t s_ri_q;
    cnt_t s_wr_d;
    cnt_t s_wr_q;
    cnt_t s_wi_d;
    cnt_t s_wi_q;
    stl_t s_mr_d;
    stl_t s_mr_q;
    stl_t s_mw_d;
    stl_t s_mw_q;
    logic tog_d;
    logic tog_q;

    // decode stage; clear flushes events in flight
    always_comb begin
        ev_d = decode_ev(enable_i, app_en, app_rdy, app_cmd,
                         app_wdf_wren, app_wdf_rdy);
        en_d = enable_i;
        if (clear_i) begin
            ev_d = '0;
            en_d = 1'b0;
        end
    end

    // decode pipeline register
    always_ff @(posedge ui_clk or posedge reset_i) begin
        if (reset_i) begin
            ev_q <= '0;
            en_q <= 1'b0;
        end else begin
            ev_q <= ev_d;
            en_q <= en_d;
        end
    end

    // saturating live event counters
    always_comb begin
        rd_cnt_d  = sat_inc(rd_cnt_q, ev_q.rd_acc);
        rd_idle_d = sat_inc(rd_idle_q, ev_q.rd_stall);
        wr_cnt_d  = sat_inc(wr_cnt_q, ev_q.wr_acc);
        wr_idle_d = sat_inc(wr_idle_q, ev_q.wr_stall);
        if (clear_i) begin
            rd_cnt_d  = '0;
            rd_idle_d = '0;
            wr_cnt_d  = '0;
            wr_idle_d = '0;
        end
    end

    // live counter registers
    always_ff @(posedge ui_clk or posedge reset_i) begin
        if (reset_i) begin
            rd_cnt_q  <= '0;
            rd_idle_q <= '0;
            wr_cnt_q  <= '0;
            wr_idle_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            rd_idle_q <= rd_idle_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_idle_q <= wr_idle_d;
        end
    end

    ddr3_stall_tracker #(
        .pW (pSTALL_WIDTH)
    ) u_rd_trk (
        .clk     (ui_clk),
        .rst     (reset_i),
        .en_i    (en_q),
        .clr_i   (clear_i),
        .stall_i (ev_q.rd_stall),
        .peak_o  (rd_peak)
    );

    ddr3_stall_tracker #(
        .pW (pSTALL_WIDTH)
    ) u_wr_trk (
        .clk     (ui_clk),
        .rst     (reset_i),
        .en_i    (en_q),
        .clr_i   (clear_i),
        .stall_i (ev_q.wr_stall),
        .peak_o  (wr_peak)
    );

    // snapshot sequencing; a clear queues one LOAD after it drops
    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        pend_d  = pend_q;
        load    = 1'b0;
        if (clear_i) begin
            per_d   = '0;
            pend_d  = 1'b1;
            state_d = enable_i ? ST_COUNT : ST_IDLE;
        end else if (pend_q) begin
            per_d   = '0;
            pend_d  = 1'b0;
            state_d = ST_LOAD;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    per_d = '0;
                    if (enable_i) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!enable_i || (per_q == TERM)) begin
                        per_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        per_d = per_q + P_ONE;
                    end
                end
                ST_LOAD: begin
                    load    = 1'b1;
                    per_d   = '0;
                    state_d = enable_i ? ST_COUNT : ST_IDLE;
                end
                default: begin
                    per_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM registers
    always_ff @(posedge ui_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            per_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            pend_q  <= pend_d;
        end
    end

    // snapshot copy; outputs move only on load
    always_comb begin
        s_rd_d = s_rd_q;
        s_ri_d = s_ri_q;
        s_wr_d = s_wr_q;
        s_wi_d = s_wi_q;
        s_mr_d = s_mr_q;
        s_mw_d = s_mw_q;
        tog_d  = tog_q;
        if (load) begin
            s_rd_d = rd_cnt_q;
            s_ri_d = rd_idle_q;
            s_wr_d = wr_cnt_q;
            s_wi_d = wr_idle_q;
            s_mr_d = rd_peak;
            s_mw_d = wr_peak;
            tog_d  = ~tog_q;
        end
    end

    // snapshot registers
    always_ff @(posedge ui_clk or posedge reset_i) begin
        if (reset_i) begin
            s_rd_q <= '0;
            s_ri_q <= '0;
            s_wr_q <= '0;
            s_wi_q <= '0;
            s_mr_q <= '0;
            s_mw_q <= '0;
            tog_q  <= 1'b0;
        end else begin
            s_rd_q <= s_rd_d;
            s_ri_q <= s_ri_d;
            s_wr_q <= s_wr_d;
            s_wi_q <= s_wi_d;
            s_mr_q <= s_mr_d;
            s_mw_q <= s_mw_d;
            tog_q  <= tog_d;
        end
    end

    assign read_read_o       = s_rd_q;
    assign read_idle_o       = s_ri_q;
    assign write_write_o     = s_wr_q;
    assign write_idle_o      = s_wi_q;
    assign max_read_stall_o  = s_mr_q;
    assign max_write_stall_o = s_mw_q;
    assign snap_toggle_o     = tog_q;

endmodule
